// File: rtl/dc_ipu_filter_cubic_apply.sv
// dc_ipu_filter_cubic_apply: 4-tap cubic interpolation filter apply stage.
// Holds a 4-pixel window, multiplies by per-sample signed weights and rounds
// the weighted sum back to a pixel through a 3-stage pipeline.
// Optional feature macro: DC_IPU_FILTER_CUBIC_APPLY_CLAMP_EN
//   defined   -> result saturates to [0, 2^PIXEL_WIDTH-1]
//   undefined -> result keeps the low PIXEL_WIDTH bits (wraps)
module dc_ipu_filter_cubic_apply #(
  parameter int unsigned PIXEL_WIDTH        = 8,
  parameter int unsigned WEIGHT_WIDTH       = 12,
  parameter int unsigned WEIGHT_FRACT_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           en,
  input  logic                           in_push,
  input  logic                           in_sol,
  input  logic [PIXEL_WIDTH-1:0]         in_pixel,
  input  logic                           in_fire,
  input  logic signed [WEIGHT_WIDTH-1:0] weights [0:3],
  output logic                           out_valid,
  output logic [PIXEL_WIDTH-1:0]         out_pixel,
  output logic                           err
);

  localparam int unsigned PROD_W = PIXEL_WIDTH + 1 + WEIGHT_WIDTH;
  localparam int unsigned SUM_W  = PROD_W + 2;
  localparam int unsigned RND_W  = SUM_W + 1;
  localparam int unsigned RES_W  = RND_W - WEIGHT_FRACT_WIDTH;
  localparam logic [RND_W-1:0] ROUND_C = RND_W'(1) << (WEIGHT_FRACT_WIDTH - 1);

  logic [PIXEL_WIDTH-1:0]   r_tap [0:3];
  logic                     r_window_ok;
  logic                     r_err;
  logic signed [PROD_W-1:0] r_prod [0:3];
  logic                     r_v0;
  logic signed [SUM_W-1:0]  r_sum;
  logic                     r_v1;
  logic [PIXEL_WIDTH-1:0]   r_pix;
  logic                     r_v2;

  logic signed [PROD_W-1:0] w_prod [0:3];
  logic signed [SUM_W-1:0]  w_sum;
  logic [PIXEL_WIDTH-1:0]   w_res;

  // Products of unsigned taps (zero-extended) with signed weights
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_prod[i] = $signed({{(PROD_W - PIXEL_WIDTH){1'b0}}, r_tap[i]}) *
                  $signed({{(PROD_W - WEIGHT_WIDTH){weights[i][WEIGHT_WIDTH-1]}}, weights[i]});
    end
  end

  // Sum of the four products with two guard bits
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 4; i++) begin
      w_sum = w_sum + $signed({{2{r_prod[i][PROD_W-1]}}, r_prod[i]});
    end
  end

`ifdef DC_IPU_FILTER_CUBIC_APPLY_CLAMP_EN
  logic signed [RES_W-1:0] w_rounded;

  // Round half up, drop fraction, saturate to the pixel range
  always_comb begin
    w_rounded = RES_W'(($signed({r_sum[SUM_W-1], r_sum}) + $signed(ROUND_C)) >>> WEIGHT_FRACT_WIDTH);
    if (w_rounded[RES_W-1]) begin
      w_res = '0;
    end else if (|w_rounded[RES_W-2:PIXEL_WIDTH]) begin
      w_res = '1;
    end else begin
      w_res = w_rounded[PIXEL_WIDTH-1:0];
    end
  end
`else
  // Round half up, drop fraction, keep the low pixel bits
  always_comb begin
    w_res = PIXEL_WIDTH'(($signed({r_sum[SUM_W-1], r_sum}) + $signed(ROUND_C)) >>> WEIGHT_FRACT_WIDTH);
  end
`endif

  // Tap window: shift on push, replicate the pixel on start of line; sticky err
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 4; i++) r_tap[i] <= '0;
      r_window_ok <= 1'b0;
      r_err       <= 1'b0;
    end else if (en) begin
      if (in_push) begin
        if (in_sol) begin
          for (int i = 0; i < 4; i++) r_tap[i] <= in_pixel;
          r_window_ok <= 1'b1;
        end else begin
          r_tap[0] <= r_tap[1];
          r_tap[1] <= r_tap[2];
          r_tap[2] <= r_tap[3];
          r_tap[3] <= in_pixel;
        end
      end
      if (in_fire && !r_window_ok) r_err <= 1'b1;
    end
  end

  // Stage 0: register products taken from the pre-push window
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 4; i++) r_prod[i] <= '0;
      r_v0 <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < 4; i++) r_prod[i] <= w_prod[i];
      r_v0 <= in_fire;
    end
  end

  // Stage 1: register the accumulated sum
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sum <= '0;
      r_v1  <= 1'b0;
    end else if (en) begin
      r_sum <= w_sum;
      r_v1  <= r_v0;
    end
  end

  // Stage 2: register the rounded output pixel
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_pix <= '0;
      r_v2  <= 1'b0;
    end else if (en) begin
      r_pix <= w_res;
      r_v2  <= r_v1;
    end
  end

  assign out_valid = r_v2;
  assign out_pixel = r_pix;
  assign err       = r_err;

endmodule

// File: tb/tb_dc_ipu_filter_cubic_apply.sv
// tb_dc_ipu_filter_cubic_apply: directed and random checks of the cubic apply
// filter against an arithmetic reference model of window, latency and rounding.
// Honours DC_IPU_FILTER_CUBIC_APPLY_CLAMP_EN for the expected result mode.
module tb_dc_ipu_filter_cubic_apply;

  localparam int unsigned PW = 8;
  localparam int unsigned WW = 12;
  localparam int unsigned FW = 10;
  localparam int PMAX = (1 << PW) - 1;

  logic                 clk;
  logic                 nreset;
  logic                 en;
  logic                 in_push;
  logic                 in_sol;
  logic [PW-1:0]        in_pixel;
  logic                 in_fire;
  logic signed [WW-1:0] weights [0:3];
  logic                 out_valid;
  logic [PW-1:0]        out_pixel;
  logic                 err;

  dc_ipu_filter_cubic_apply #(
    .PIXEL_WIDTH(PW), .WEIGHT_WIDTH(WW), .WEIGHT_FRACT_WIDTH(FW)
  ) dut (
    .clk(clk), .nreset(nreset), .en(en), .in_push(in_push), .in_sol(in_sol),
    .in_pixel(in_pixel), .in_fire(in_fire), .weights(weights),
    .out_valid(out_valid), .out_pixel(out_pixel), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // reference model state
  typedef struct { int due; int val; } exp_t;
  exp_t q[$];
  int   m_win [0:3];
  bit   m_ok;
  bit   m_err;
  int   m_edges;
  bit   m_valid;
  int   m_pix;
  int   last_out;
  int   valid_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_pixel(input int acc);
    int r;
    r = (acc + (1 << (FW - 1))) >>> FW;
`ifdef DC_IPU_FILTER_CUBIC_APPLY_CLAMP_EN
    if (r < 0) r = 0;
    if (r > PMAX) r = PMAX;
    return r;
`else
    return r & PMAX;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 4; i++) m_win[i] = 0;
    m_ok = 0; m_err = 0; m_valid = 0; m_pix = 0;
  endtask

  // Apply one cycle of inputs, advance the model, compare outputs after the edge
  task automatic cycle(input bit e, input bit p, input bit s, input int pix,
                       input bit f, input int w0, input int w1, input int w2, input int w3);
    int wv [0:3];
    int acc;
    exp_t it;
    wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
    en = e; in_push = p; in_sol = s; in_pixel = PW'(pix); in_fire = f;
    for (int i = 0; i < 4; i++) weights[i] = WW'(wv[i]);
    @(posedge clk);
    #1;
    if (e) begin
      m_edges++;
      if (f) begin
        acc = 0;
        for (int i = 0; i < 4; i++) acc += m_win[i] * wv[i];
        if (!m_ok) m_err = 1;
        it.due = m_edges + 2;
        it.val = ref_pixel(acc);
        q.push_back(it);
      end
      if (p) begin
        if (s) begin
          for (int i = 0; i < 4; i++) m_win[i] = pix;
          m_ok = 1;
        end else begin
          for (int i = 0; i < 3; i++) m_win[i] = m_win[i+1];
          m_win[3] = pix;
        end
      end
      m_valid = 0;
      if (q.size() > 0 && q[0].due == m_edges) begin
        it = q.pop_front();
        m_valid = 1;
        m_pix = it.val;
      end
      if (out_valid) begin
        valid_cnt++;
        last_out = int'(out_pixel);
      end
    end
    check("valid", int'(out_valid), int'(m_valid));
    if (m_valid) check("pixel", int'(out_pixel), m_pix);
    check("err", int'(err), int'(m_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #2;
    check("rst_valid", int'(out_valid), 0);
    check("rst_pixel", int'(out_pixel), 0);
    check("rst_err", int'(err), 0);
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_edges = 0; last_out = -1; valid_cnt = 0;
    en = 0; in_push = 0; in_sol = 0; in_pixel = '0; in_fire = 0;
    for (int i = 0; i < 4; i++) weights[i] = '0;
    model_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // flat window of 100 reproduces 100
    cycle(1, 1, 1, 100, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, -64, 576, 576, -64);
    idle(4);
    check("flat100", last_out, 100);

    // overshoot above full scale
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 255, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 255, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, -64, 576, 576, -64);
    idle(4);
`ifdef DC_IPU_FILTER_CUBIC_APPLY_CLAMP_EN
    check("overshoot", last_out, 255);
`else
    check("overshoot", last_out, 31);
`endif

    // undershoot below zero
    cycle(1, 1, 1, 255, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 255, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, -64, 576, 576, -64);
    idle(4);
`ifdef DC_IPU_FILTER_CUBIC_APPLY_CLAMP_EN
    check("undershoot", last_out, 0);
`else
    check("undershoot", last_out, 224);
`endif

    // three fires separated by two-cycle stalls
    valid_cnt = 0;
    cycle(1, 1, 1, 50, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 100, 200, 300, 424);
    cycle(0, 0, 0, 0, 1, 100, 200, 300, 424);
    cycle(0, 0, 0, 0, 1, 100, 200, 300, 424);
    cycle(1, 0, 0, 0, 1, 0, 512, 512, 0);
    cycle(0, 1, 0, 7, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 7, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 1024, 0, 0, 0);
    idle(5);
    check("stall_pulses", valid_cnt, 3);

    // fire with no window sets sticky err; reset with samples in flight
    do_reset();
    cycle(1, 0, 0, 0, 1, 300, 300, 300, 300);
    idle(3);
    check("err_set", int'(err), 1);
    cycle(1, 1, 1, 60, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 256, 256, 256, 256);
    idle(4);
    check("err_sticky", int'(err), 1);
    cycle(1, 0, 0, 0, 1, 256, 256, 256, 256);
    cycle(1, 0, 0, 0, 1, 256, 256, 256, 256);
    valid_cnt = 0;
    do_reset();
    idle(5);
    check("flush_pulses", valid_cnt, 0);

    // fire coinciding with a push sees the pre-push window
    cycle(1, 1, 1, 10, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 20, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 30, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 40, 1, 0, 0, 0, 1024);
    cycle(1, 0, 0, 0, 1, 0, 0, 0, 1024);
    idle(1);
    check("prepush", last_out, 30);
    idle(1);
    check("postpush", last_out, 40);

    // randomized traffic
    cycle(1, 1, 1, $urandom_range(0, PMAX), 0, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 15) == 0), $urandom_range(0, PMAX),
            ($urandom_range(0, 2) != 0),
            int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
            int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dc_ipu_filter_cubic_apply.md
DC_IPU_FILTER_CUBIC_APPLY -- requirements
Module: dc_ipu_filter_cubic_apply

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, meaning unsigned pixel component width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 12, meaning signed two's-complement weight width.
REQ-003 SHALL have parameter WEIGHT_FRACT_WIDTH, default 10, meaning weight fraction bits (1.0 = 2^WEIGHT_FRACT_WIDTH).
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  global pipeline enable; low = full stall.
REQ-007 SHALL have port in_push  input  1  shift in_pixel into the tap window.
REQ-008 SHALL have port in_sol  input  1  start of line, qualified by in_push.
REQ-009 SHALL have port in_pixel  input  PIXEL_WIDTH  unsigned pixel pushed.
REQ-010 SHALL have port in_fire  input  1  compute one output sample from the current window.
REQ-011 SHALL have port weights[0:3]  input  4 x WEIGHT_WIDTH signed  cubic weights, time-aligned with in_fire.
REQ-012 SHALL have port out_valid  output  1  out_pixel holds a new sample this cycle.
REQ-013 SHALL have port out_pixel  output  PIXEL_WIDTH  filtered pixel.
REQ-014 SHALL have port err  output  1  sticky: in_fire seen with no valid window.

Function
REQ-015 SHALL hold a 4-entry window tap[0..3], with tap[0] the oldest; weights[i] multiplies tap[i].
REQ-016 SHALL, on en & in_push & !in_sol, shift tap[0]<-tap[1], tap[1]<-tap[2], tap[2]<-tap[3], tap[3]<-in_pixel.
REQ-017 SHALL, on en & in_push & in_sol, load all four taps with in_pixel (edge replication) and set window_ok.
REQ-018 SHALL, when in_fire and in_push coincide, compute from the window contents before that cycle's push.
REQ-019 SHALL use stage 0 to register the 4 products, each the signed value {1'b0,tap[i]} times weights[i], PIXEL_WIDTH+1+WEIGHT_WIDTH bits wide.
REQ-020 SHALL use stage 1 to register the sum of the 4 products, with 2 guard bits and no overflow.
REQ-021 SHALL use stage 2 to register the result: add 2^(WEIGHT_FRACT_WIDTH-1), arithmetic shift right by WEIGHT_FRACT_WIDTH (round half up), then saturate or wrap per REQ-031/032.
REQ-022 SHALL carry a valid bit alongside stages 0, 1 and 2; out_valid is the stage 2 valid bit.
REQ-023 SHALL have a latency of exactly 3 en-high rising edges from in_fire to out_valid, with a throughput of one sample per en-high cycle.
REQ-024 SHALL, while en is low, hold all registers (taps, window_ok, stage data, valids, err); in_push and in_fire are ignored; out_valid and out_pixel hold their values.
REQ-025 SHALL, on en & in_fire & !window_ok, set err, still issue the sample (computed on the zero taps), and keep err set until reset.
REQ-026 SHALL NOT clear window_ok at end of line; only reset clears it.

Reset
REQ-027 SHALL clear, on nreset low, all taps, window_ok, stage registers, valid bits and err to 0 asynchronously; out_valid=0 and out_pixel=0.
REQ-028 SHALL discard any in-flight samples on reset mid-pipeline; no out_valid is produced for them after release.
REQ-029 SHALL accept in_push/in_fire on the first en-high edge after nreset deasserts.

Configuration
REQ-030 SHALL use the macro DC_IPU_FILTER_CUBIC_APPLY_CLAMP_EN.
REQ-031 SHALL, when the macro is defined, saturate the stage 2 result to [0, 2^PIXEL_WIDTH-1].
REQ-032 SHALL, when the macro is undefined, pass the low PIXEL_WIDTH bits of the rounded result unchanged (wrap); the logic is otherwise identical.

Verification (PIXEL_WIDTH=8, WEIGHT_WIDTH=12, WEIGHT_FRACT_WIDTH=10)
REQ-033 SHALL cover: push 100 with sol, then fire with weights {-64,576,576,-64} -> out_valid 3 en-cycles later, out_pixel=100, err=0.
REQ-034 SHALL cover: sol 0, push 255, push 255, push 0, then fire with {-64,576,576,-64} -> with CLAMP_EN out_pixel=255; without it out_pixel=31 (287 mod 256).
REQ-035 SHALL cover: sol 255, push 0, push 0, push 255, then fire with {-64,576,576,-64} -> rounded value -32; with CLAMP_EN out_pixel=0; without it out_pixel=224.
REQ-036 SHALL cover: fire on 3 consecutive cycles with en low for 2 cycles in between -> 3 out_valid pulses, each delayed by exactly the stall length, values unchanged.
REQ-037 SHALL cover: fire after reset with no sol -> err=1 and stays 1 through later valid traffic; nreset pulse with 2 samples in flight -> no out_valid after release, err=0.
REQ-038 SHALL cover: sol 10, push 20, push 30, push 40 with same-cycle fire using {0,0,0,1024} -> out_pixel=30 (pre-push window); next fire -> 40.
